mux_select_sequencer: RTL and testbench
=======================================

# mux_select_sequencer

Consumer side of the button-driven source selector. Takes the 3-bit select code produced by `mux_control` and turns it into one-hot source enables for the downstream video/data sources. Uses break-before-make switching: on every select change, all enables drop for a fixed blanking interval before the new source is enabled, so two sources are never driven at once. Reports completion with a one-cycle `changed` pulse and a `blank` status flag.

## Interface

- `NUM_SRC`, 5: number of selectable sources. Legal range is 1..8. Select codes `>= NUM_SRC` are invalid.
- `BLANK_CYCLES`, 4: number of cycles all enables are held low during a switch. Must be `>= 1`.
- `SEL_W`, 3: width of the select code.

- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sel` in SEL_W: requested source code from `mux_control`; sampled every cycle.
- `enable` out NUM_SRC: one-hot source enable, or all-zero while blanking.
- `active_sel` out SEL_W: code of the source currently enabled (last committed).
- `blank` out 1: high while in the blanking interval.
- `changed` out 1: one-cycle pulse on the cycle the new source is first enabled.

## Operation

- Reset values: `enable = 1` (source 0), `active_sel = 0`, `blank = 0`, `changed = 0`, state STEADY, counter 0, pending 0.
- States:
  - STEADY: holds the committed source.
  - BREAK: all enables off; counts down the blanking interval.
- STEADY:
  - If `sel < NUM_SRC` and `sel != active_sel`: latch pending = `sel`, load counter = `BLANK_CYCLES-1`, set `enable = 0` and `blank = 1`, go to BREAK.
  - An invalid code (`sel >= NUM_SRC`) is ignored; nothing changes.
  - A code equal to `active_sel` is ignored.
- BREAK:
  - Each cycle, if `sel` is valid, pending = `sel`. This is a retarget; the counter is **not** restarted.
  - An invalid `sel` leaves pending unchanged.
  - If the counter is nonzero, decrement it.
  - If the counter is 0: set `enable = onehot(pending)`, `active_sel = pending`, `blank = 0`, `changed = 1`, and go to STEADY.
- Retarget back to the original `active_sel` during BREAK: blanking still completes in full, then the original source is re-enabled and `changed` still pulses.
- `changed` is high for exactly one cycle. The cycle after it is deasserted unless a new commit occurs.
- `enable` is always one-hot or all-zero. It is all-zero iff `blank = 1`.
- `reset` asserted in any state, including mid-BREAK, restores the reset values on the next edge. The pending switch is discarded.

## Timing

- Let the rising edge N sample a valid `sel` that differs from `active_sel`. Then:
  - After edge N: `enable = 0`, `blank = 1`.
  - After edges N+1 .. N+BLANK_CYCLES-1: still blanking.
  - After edge N+BLANK_CYCLES: new enable, `blank = 0`, `changed = 1`.
- Blank duration is exactly BLANK_CYCLES cycles. Select-to-enable latency is BLANK_CYCLES+1 edges, counted from the sampling edge.
- With `BLANK_CYCLES = 1`: one blank cycle, then commit on the following edge.
- STEADY accepts a new request on the cycle `changed` is high. Back-to-back switches therefore have no idle gap beyond the single commit cycle.
- No combinational path from `sel` to any output. All outputs are registered.

## Test plan

- Reset, then `sel = 0` held -> `enable = 5'b00001`, `active_sel = 0`, `blank = 0`, `changed = 0` throughout.
- Defaults. `sel` goes 0 -> 2 at edge N -> `enable = 0` and `blank = 1` for 4 cycles. After edge N+4: `enable = 5'b00100`, `active_sel = 2`, `changed` high for 1 cycle.
- During blanking toward 2, `sel = 4` one cycle after the start -> commit still at N+4, with `enable = 5'b10000` and `active_sel = 4`. During blanking, `sel` returned to 0 -> commit at N+4 with `enable = 5'b00001` and a `changed` pulse.
- `sel = 5`, 6 or 7 in STEADY (active 1) -> no blanking, `enable = 5'b00010` unchanged. The same codes during BREAK -> pending is unaffected.
- `reset` pulsed at the second blank cycle of a 0 -> 3 switch -> next cycle `enable = 5'b00001`, `blank = 0`, `active_sel = 0`, no `changed` pulse.
- `sel` stepping 1, 3, 23, 12, 31 (truncated to 3 bits), 1 every 10 cycles, mirroring `mux_control` output -> the `enable` one-hot/all-zero invariant and `blank == (enable == 0)` both checked every cycle.

Source files
------------

// File: rtl/mux_select_sequencer.sv
// Break-before-make source selector: turns a select code into one-hot
// enables, blanking all of them for BLANK_CYCLES before each switch.
module mux_select_sequencer #(
  parameter int NUM_SRC      = 5,
  parameter int BLANK_CYCLES = 4,
  parameter int SEL_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_SRC-1:0] enable,
  output logic [SEL_W-1:0]   active_sel,
  output logic               blank,
  output logic               changed
);

  localparam int CNT_W =
    (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W:0] SRC_LIM =
    (SEL_W + 1)'(NUM_SRC);

  typedef enum logic {
    ST_STEADY,
    ST_BREAK
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_pend;
  logic [SEL_W-1:0]   w_pend_nxt;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] w_enable_nxt;
  logic [SEL_W-1:0]   r_active;
  logic [SEL_W-1:0]   w_active_nxt;
  logic               r_blank;
  logic               w_blank_nxt;
  logic               r_changed;
  logic               w_changed_nxt;
  logic               w_valid;

  assign w_valid = ({1'b0, sel} < SRC_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_STEADY;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_enable  <= NUM_SRC'(1);
      r_active  <= '0;
      r_blank   <= 1'b0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_enable  <= w_enable_nxt;
      r_active  <= w_active_nxt;
      r_blank   <= w_blank_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_nxt    = r_pend;
    w_enable_nxt  = r_enable;
    w_active_nxt  = r_active;
    w_blank_nxt   = r_blank;
    w_changed_nxt = 1'b0;
    unique case (r_state)
      ST_STEADY: begin
        if (w_valid && (sel != r_active)) begin
          w_pend_nxt   = sel;
          w_cnt_nxt    = CNT_LOAD;
          w_enable_nxt = '0;
          w_blank_nxt  = 1'b1;
          w_state_nxt  = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Retargets update pending but never restart the blank count
        if (w_valid) begin
          w_pend_nxt = sel;
        end
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_enable_nxt  = NUM_SRC'(1) << w_pend_nxt;
          w_active_nxt  = w_pend_nxt;
          w_blank_nxt   = 1'b0;
          w_changed_nxt = 1'b1;
          w_state_nxt   = ST_STEADY;
        end
      end
      default: begin
        w_state_nxt = ST_STEADY;
      end
    endcase
  end

  always_comb begin
    enable     = r_enable;
    active_sel = r_active;
    blank      = r_blank;
    changed    = r_changed;
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer with default parameters
// (5 sources, 4 blank cycles).
module tb_mux_select_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] sel;
  logic [4:0] enable;
  logic [2:0] active_sel;
  logic       blank;
  logic       changed;

  int checks;
  int errors;

  mux_select_sequencer #(
    .NUM_SRC(5),
    .BLANK_CYCLES(4),
    .SEL_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sel(sel),
    .enable(enable),
    .active_sel(active_sel),
    .blank(blank),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] en,
                     input logic [2:0] act, input logic blk,
                     input logic chg);
    cmp({tag, ".enable"}, {3'b0, enable}, {3'b0, en});
    cmp({tag, ".active"}, {5'b0, active_sel}, {5'b0, act});
    cmp({tag, ".blank"}, {7'b0, blank}, {7'b0, blk});
    cmp({tag, ".changed"}, {7'b0, changed}, {7'b0, chg});
  endtask

  task automatic inv(input string tag);
    cmp({tag, ".onehot0"}, {7'b0, $onehot0(enable)}, 8'd1);
    cmp({tag, ".blankeq"}, {7'b0, blank}, {7'b0, (enable == 5'b0)});
  endtask

  initial begin
    logic [4:0] sweep [6];
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    sel    = 3'd0;
    step();
    step();
    chk("rst", 5'b00001, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle0", 5'b00001, 3'd0, 1'b0, 1'b0);
    end

    // 0 -> 2 basic switch
    sel = 3'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sw2.blank", 5'b00000, 3'd0, 1'b1, 1'b0);
    end
    step();
    chk("sw2.commit", 5'b00100, 3'd2, 1'b0, 1'b1);
    step();
    chk("sw2.after", 5'b00100, 3'd2, 1'b0, 1'b0);

    // 2 -> 1 retargeted to 4 one cycle later
    sel = 3'd1;
    step();
    chk("rt4.start", 5'b00000, 3'd2, 1'b1, 1'b0);
    sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rt4.blank", 5'b00000, 3'd2, 1'b1, 1'b0);
    end
    step();
    chk("rt4.commit", 5'b10000, 3'd4, 1'b0, 1'b1);

    // 4 -> 0 retargeted back to 4: full blank, then pulse
    sel = 3'd0;
    step();
    chk("back.start", 5'b00000, 3'd4, 1'b1, 1'b0);
    sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("back.blank", 5'b00000, 3'd4, 1'b1, 1'b0);
    end
    step();
    chk("back.commit", 5'b10000, 3'd4, 1'b0, 1'b1);

    // move to 1, then invalid codes in STEADY
    sel = 3'd1;
    for (int i = 0; i < 4; i++) step();
    step();
    chk("sw1.commit", 5'b00010, 3'd1, 1'b0, 1'b1);
    for (int c = 5; c < 8; c++) begin
      sel = 3'(c);
      step();
      chk("inv.steady", 5'b00010, 3'd1, 1'b0, 1'b0);
    end

    // invalid codes during BREAK leave pending alone
    sel = 3'd3;
    step();
    chk("inv.brk.start", 5'b00000, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sel = 3'(5 + i);
      step();
      chk("inv.brk.blank", 5'b00000, 3'd1, 1'b1, 1'b0);
    end
    sel = 3'd7;
    step();
    chk("inv.brk.commit", 5'b01000, 3'd3, 1'b0, 1'b1);

    // back to 0, then reset in the middle of 0 -> 3
    sel = 3'd0;
    for (int i = 0; i < 4; i++) step();
    step();
    chk("sw0.commit", 5'b00001, 3'd0, 1'b0, 1'b1);
    sel = 3'd3;
    step();
    step();
    chk("rstmid.blank2", 5'b00000, 3'd0, 1'b1, 1'b0);
    reset = 1'b1;
    sel   = 3'd0;
    step();
    chk("rstmid.rst", 5'b00001, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstmid.after", 5'b00001, 3'd0, 1'b0, 1'b0);
    end

    // mux_control-style sweep, codes truncated to 3 bits
    sweep[0] = 5'd1;
    sweep[1] = 5'd3;
    sweep[2] = 5'd23;
    sweep[3] = 5'd12;
    sweep[4] = 5'd31;
    sweep[5] = 5'd1;
    for (int k = 0; k < 6; k++) begin
      sel = sweep[k][2:0];
      for (int i = 0; i < 10; i++) begin
        step();
        inv("sweep");
      end
    end
    chk("sweep.end", 5'b00010, 3'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
